// File: rtl/potato_pkg.sv
// ============================================================================
//  Module   : potato_pkg
//  Purpose  : Shared constants for the Potato control unit. It holds the
//             micro-instruction indices, the loop controller state encoding
//             and the default widths.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package potato_pkg;

    // Bit positions of the decoded micro-instruction vector
    localparam int CTRL_INC   = 0;
    localparam int CTRL_DEC   = 1;
    localparam int CTRL_LEFT  = 2;
    localparam int CTRL_RIGHT = 3;
    localparam int CTRL_OUT   = 4;
    localparam int CTRL_IN    = 5;
    localparam int CTRL_LOOP  = 6;
    localparam int CTRL_DONE  = 7;
    localparam int CTRL_WIDTH = 8;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_SKIP_FWD  = 2'd1;
    localparam logic [1:0] ST_SCAN_BACK = 2'd2;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_STACK_DEPTH = 8;
    localparam int DEF_NEST_WIDTH  = 16;

endpackage

`default_nettype wire

// File: rtl/loop_addr_stack.sv
// ============================================================================
//  Module   : loop_addr_stack
//  Purpose  : LIFO of loop-start addresses. When push and pop arrive together
//             on a non-empty stack, the new entry replaces the top entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_addr_stack
    import potato_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                               Clock,
    input  logic                               Reset_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_WIDTH-1:0]              data_in,
    output logic [ADDR_WIDTH-1:0]              top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam logic [DW-1:0] c_one  = DW'(1);
    localparam logic [DW-1:0] c_full = DW'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [DW-1:0]         r_depth;

    logic          w_replace;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_wr_idx;

    always_comb begin
        w_replace = push && pop && !empty;
        w_push_ok = push && !w_replace && !full;
        w_pop_ok  = pop && !push && !empty;
        w_top_idx = IW'(r_depth - c_one);
        w_wr_idx  = w_replace ? w_top_idx : IW'(r_depth);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_depth <= '0;
        end else if (w_push_ok) begin
            r_depth <= r_depth + c_one;
        end else if (w_pop_ok) begin
            r_depth <= r_depth - c_one;
        end
    end

    // Entries above the depth pointer are never read, so storage needs no reset
    always_ff @(posedge Clock) begin
        if (w_replace || w_push_ok) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    assign depth = r_depth;
    assign full  = (r_depth == c_full);
    assign empty = (r_depth == '0);
    assign top   = empty ? '0 : r_mem[w_top_idx];

endmodule

`default_nettype wire

// File: rtl/loop_stack_control.sv
// ============================================================================
//  Module   : loop_stack_control
//  Purpose  : Resolves loop/done micro-instructions with a stack of loop-start
//             addresses. It skips forward over zero-entry loops and can fall
//             back to a reverse scan when the stack spills.
//             Optional macro LOOP_SPILL_SCAN_EN enables the spill counter and
//             the SCAN_BACK fallback.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_stack_control
    import potato_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int NEST_WIDTH  = DEF_NEST_WIDTH
) (
    input  logic                              Clock,
    input  logic                              Reset_n,
    input  logic                              Loop,
    input  logic                              Done,
    input  logic                              ZeroFlag,
    input  logic [ADDR_WIDTH-1:0]             Pc,
    input  logic                              Stall,
    output logic                              Jump,
    output logic [ADDR_WIDTH-1:0]             JumpAddr,
    output logic                              SkipCmd,
    output logic                              Reverse,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  Depth,
    output logic                              Overflow,
    output logic                              Underflow
);

    localparam logic [NEST_WIDTH-1:0] c_nest_one = NEST_WIDTH'(1);
    localparam logic [NEST_WIDTH-1:0] c_nest_max = '1;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    logic [1:0]            r_state;
    logic [NEST_WIDTH-1:0] r_nest;
    logic                  r_jump;
    logic [ADDR_WIDTH-1:0] r_jump_addr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [1:0]            w_state_d;
    logic [NEST_WIDTH-1:0] w_nest_d;
    logic                  w_jump_d;
    logic [ADDR_WIDTH-1:0] w_jaddr_d;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_top;
    logic                  w_full;
    logic                  w_empty;

`ifdef LOOP_SPILL_SCAN_EN
    logic [NEST_WIDTH-1:0] r_spill;
    logic [NEST_WIDTH-1:0] w_spill_d;
`endif

    loop_addr_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .data_in (Pc),
        .top     (w_top),
        .depth   (Depth),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        w_state_d = r_state;
        w_nest_d  = r_nest;
        w_jump_d  = 1'b0;
        w_jaddr_d = r_jump_addr;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
`ifdef LOOP_SPILL_SCAN_EN
        w_spill_d = r_spill;
`endif
        // A stalled cycle or a contradictory Loop+Done decode changes nothing
        if (!Stall && !(Loop && Done)) begin
            case (r_state)
                ST_RUN: begin
                    if (Loop) begin
                        if (ZeroFlag) begin
                            w_state_d = ST_SKIP_FWD;
                            w_nest_d  = c_nest_one;
                        end else if (!w_full) begin
                            w_push = 1'b1;
                        end else begin
`ifdef LOOP_SPILL_SCAN_EN
                            if (r_spill == c_nest_max) begin
                                w_ovf_set = 1'b1;
                            end else begin
                                w_spill_d = r_spill + c_nest_one;
                            end
`else
                            w_ovf_set = 1'b1;
`endif
                        end
                    end else if (Done) begin
                        if (ZeroFlag) begin
`ifdef LOOP_SPILL_SCAN_EN
                            if (r_spill != '0) begin
                                w_spill_d = r_spill - c_nest_one;
                            end else
`endif
                            if (!w_empty) begin
                                w_pop = 1'b1;
                            end else begin
                                w_unf_set = 1'b1;
                            end
                        end else begin
`ifdef LOOP_SPILL_SCAN_EN
                            // Spilled loop has no stored address: scan for it
                            if (r_spill != '0) begin
                                w_state_d = ST_SCAN_BACK;
                                w_nest_d  = c_nest_one;
                            end else
`endif
                            if (!w_empty) begin
                                w_jump_d  = 1'b1;
                                w_jaddr_d = w_top + c_addr_one;
                            end else begin
                                w_unf_set = 1'b1;
                            end
                        end
                    end
                end
                ST_SKIP_FWD: begin
                    if (Loop) begin
                        if (r_nest == c_nest_max) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_nest_d = r_nest + c_nest_one;
                        end
                    end else if (Done) begin
                        w_nest_d = r_nest - c_nest_one;
                        if (r_nest == c_nest_one) begin
                            w_state_d = ST_RUN;
                        end
                    end
                end
                ST_SCAN_BACK: begin
                    if (Done) begin
                        if (r_nest == c_nest_max) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_nest_d = r_nest + c_nest_one;
                        end
                    end else if (Loop) begin
                        w_nest_d = r_nest - c_nest_one;
                        if (r_nest == c_nest_one) begin
                            w_state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_RUN;
                    w_nest_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_RUN;
            r_nest      <= '0;
            r_jump      <= 1'b0;
            r_jump_addr <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_nest      <= w_nest_d;
            r_jump      <= w_jump_d;
            r_jump_addr <= w_jaddr_d;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef LOOP_SPILL_SCAN_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_spill <= '0;
        end else begin
            r_spill <= w_spill_d;
        end
    end

    assign Reverse = (r_state == ST_SCAN_BACK);
`else
    assign Reverse = 1'b0;
`endif

    assign Jump      = r_jump;
    assign JumpAddr  = r_jump_addr;
    assign SkipCmd   = (r_state != ST_RUN);
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

endmodule

`default_nettype wire
